// File: rtl/shift_add_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mult_state_t;

  // Bits needed for a counter that must reach w itself.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_ctrl.sv
// Controller for the shift-add multiplier: IDLE/CALC/FIX sequencing and exit test.
// Latency: CALC for WIDTH cycles (fewer with early exit), one FIX cycle, then done.
// Backpressure: start is accepted only while ready; requests while busy are dropped.
module shift_add_ctrl
  import shift_add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0,
  parameter int CW         = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mplier_zero,
  input  logic [CW-1:0] cnt,
  output logic          load,
  output logic          step,
  output logic          fix,
  output logic          ready,
  output logic          busy,
  output logic          done
);

  mult_state_t state;
  logic        last_step;

  // The bit being retired this cycle is the final one, or nothing is left to retire.
  assign last_step = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && mplier_zero);

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);
  assign load  = start && ready;
  assign step  = (state == CALC);
  assign fix   = (state == FIX);

  // Sequencer with a registered one-cycle done pulse leaving FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) state <= CALC;
        CALC: if (last_step) state <= FIX;
        FIX: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, optional signed mode.
// Latency: WIDTH+2 edges from acceptance to done (shorter with early exit).
// Backpressure: ready only in IDLE; product held until the next op completes FIX.
module shift_add_mult_seq
  import shift_add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_EN  = 1'b1,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_w(WIDTH);

  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic               load;
  logic               step;
  logic               fix;
  logic               mplier_zero;

  logic               sm_eff;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_step;
  logic [CW-1:0]      rem;
  logic [2*WIDTH-1:0] acc_aligned;
  logic [2*WIDTH-1:0] product_next;

  // Magnitudes: |-2^(W-1)| wraps to 2^(W-1), which is still correct as an unsigned value.
  assign sm_eff = SIGNED_EN && signed_mode;
  assign a_neg  = sm_eff && a[WIDTH-1];
  assign b_neg  = sm_eff && b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // Multiplier bits still to be retired after this cycle's shift are all zero.
  assign mplier_zero = ~|mplier[WIDTH-1:1];

  // Add into the upper half (with carry bit), then shift the whole accumulator right.
  assign addend    = mplier[0] ? mcand : '0;
  assign upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, addend};
  assign acc_step  = {upper_sum, acc[WIDTH-1:0]} >> 1;

  // An early exit skips the trailing shifts; apply them all at once before the sign fix.
  assign rem          = CW'(WIDTH) - cnt;
  assign acc_aligned  = EARLY_EXIT ? (2*WIDTH)'(acc >> rem) : acc[2*WIDTH-1:0];
  assign product_next = neg ? -acc_aligned : acc_aligned;

  shift_add_ctrl #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT),
    .CW         (CW)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mplier_zero (mplier_zero),
    .cnt         (cnt),
    .load        (load),
    .step        (step),
    .fix         (fix),
    .ready       (ready),
    .busy        (busy),
    .done        (done)
  );

  // Datapath: load operands on acceptance, retire a bit per CALC cycle, publish in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= a_neg ^ b_neg;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_step;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end else if (fix) begin
      product <= product_next;
    end
  end

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Bench for shift_add_mult_seq: three configurations share stimulus and are
// compared against an arithmetic reference model of product and latency.
module tb_shift_add_mult_seq;

  localparam int W = 8;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;

  logic           rdy  [N];
  logic           bsy  [N];
  logic           dn   [N];
  logic [2*W-1:0] prod [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: signed, full length   1: signed, early exit   2: unsigned-only
  shift_add_mult_seq #(.WIDTH(W), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .product(prod[0]));

  shift_add_mult_seq #(.WIDTH(W), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .product(prod[1]));

  shift_add_mult_seq #(.WIDTH(W), .SIGNED_EN(1'b0), .EARLY_EXIT(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .product(prod[2]));

  function automatic bit cfg_sen(int k);
    return (k != 2);
  endfunction

  function automatic bit cfg_ee(int k);
    return (k == 1);
  endfunction

  // Reference product: plain integer multiply, truncated to 2W bits.
  function automatic logic [2*W-1:0] ref_prod(int k, logic [W-1:0] x, logic [W-1:0] y, logic sm);
    longint p;
    if (cfg_sen(k) && sm) p = longint'($signed(x)) * longint'($signed(y));
    else                  p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  // Reference latency in edges, counting the acceptance edge as the first.
  function automatic int ref_lat(int k, logic [W-1:0] y, logic sm);
    int m;
    int n;
    if (!cfg_ee(k)) return W + 2;
    m = (cfg_sen(k) && sm) ? int'($signed(y)) : int'(y);
    if (m < 0) m = -m;
    n = 0;
    while (m > 0) begin
      n++;
      m = m >> 1;
    end
    return ((n < 1) ? 1 : n) + 2;
  endfunction

  task automatic chk(string tag, longint got, longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation on all three instances; checks product, latency and pulse width.
  task automatic run_op(logic [W-1:0] x, logic [W-1:0] y, logic sm);
    int lat [N];
    int cnt [N];
    for (int k = 0; k < N; k++) begin
      lat[k] = 0;
      cnt[k] = 0;
    end
    @(negedge clk);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (dn[k]) begin
          cnt[k]++;
          if (lat[k] == 0) lat[k] = e + 1;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("prod%0d %h*%h sm=%0d", k, x, y, sm), prod[k], ref_prod(k, x, y, sm));
      chk($sformatf("lat%0d %h*%h sm=%0d", k, x, y, sm), lat[k], ref_lat(k, y, sm));
      chk($sformatf("pulses%0d", k), cnt[k], 1);
    end
  endtask

  logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    int ndone;
    int t1;
    int t2;
    logic [2*W-1:0] p1;
    logic [2*W-1:0] p2;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_ready%0d", k), rdy[k], 1);
      chk($sformatf("rst_busy%0d", k), bsy[k], 0);
      chk($sformatf("rst_done%0d", k), dn[k], 0);
      chk($sformatf("rst_prod%0d", k), prod[k], 0);
    end
    rst = 1'b0;

    // Directed corners
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'h80, 8'h80, 1'b1);
    run_op(8'h80, 8'h7F, 1'b1);
    run_op(8'hFF, 8'h01, 1'b1);
    run_op(8'h00, 8'hFB, 1'b1);
    run_op(8'd3, 8'd1, 1'b0);
    run_op(8'd3, 8'd0, 1'b0);
    run_op(8'd3, 8'h80, 1'b0);
    run_op(8'hFF, 8'h02, 1'b1);

    // Back-to-back with start held; operands scrambled while calculating
    @(negedge clk);
    a = 8'd3; b = 8'd4; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    ndone = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (dn[0]) begin
        if (ndone == 0) begin p1 = prod[0]; t1 = i; end
        else if (ndone == 1) begin p2 = prod[0]; t2 = i; end
        ndone++;
      end
      if (i >= W + 2) begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end else if (i >= 6) begin
        a = 8'd5; b = 8'd6;
      end else begin
        a = W'($urandom); b = W'($urandom);
      end
    end
    chk("b2b_first", p1, 12);
    chk("b2b_second", p2, 30);
    chk("b2b_spacing", t2 - t1, W + 2);
    chk("b2b_count", ndone, 2);
    repeat (30) @(posedge clk);

    // Reset during the fourth CALC cycle aborts the operation
    @(negedge clk);
    a = 8'd10; b = 8'd11; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", rdy[0], 1);
    chk("abort_busy", bsy[0], 0);
    chk("abort_prod", prod[0], 0);
    chk("abort_done", dn[0], 0);
    rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (dn[0] || dn[1] || dn[2]) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(8'd7, 8'd9, 1'b0);

    // Randomized operations
    repeat (40) run_op(pick(), pick(), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
